// File: rtl/usb_rx_bit_decoder.sv
// usb_rx_bit_decoder
//   USB full-speed receive front end. Oversamples D+/D-, recovers bit timing
//   from line transitions, NRZI-decodes, removes stuffed bits. It also flags
//   end-of-packet (SE0) and bit-stuff violations.
//
// Ports
//   clk         system clock (CLKS_PER_BIT clocks per USB bit)
//   n_rst       synchronous active-low reset
//   d_plus      USB D+ line
//   d_minus     USB D- line
//   rx_enable   0 forces IDLE and suppresses every output pulse
//   serial_out  last decoded, unstuffed bit (held between pulses)
//   shift_en    one-cycle pulse: serial_out carries a new data bit
//   rcving      high while a packet is in progress (RUN)
//   eop         one-cycle pulse after SE0 is sampled
//   stuff_err   one-cycle pulse after a bit-stuff violation
//
// Configuration macro
//   USB_RX_SYNC_EN : when defined, D+/D- pass through a 2-flop synchronizer
//                    (reset D+=1, D-=0). Every latency grows by 2 cycles.
module usb_rx_bit_decoder #(
    parameter int CLKS_PER_BIT  = 8,
    parameter int SAMPLE_OFFSET = 3,
    parameter int STUFF_LIMIT   = 6
) (
    input  logic clk,
    input  logic n_rst,
    input  logic d_plus,
    input  logic d_minus,
    input  logic rx_enable,
    output logic serial_out,
    output logic shift_en,
    output logic rcving,
    output logic eop,
    output logic stuff_err
);
    localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int OW = $clog2(STUFF_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, RUN, EOP_WAIT, ERR_WAIT} state_t;

    logic dp, dm;

`ifdef USB_RX_SYNC_EN
    logic [1:0] dp_sync, dm_sync;
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            dp_sync <= 2'b11;
            dm_sync <= 2'b00;
        end else begin
            dp_sync <= {dp_sync[0], d_plus};
            dm_sync <= {dm_sync[0], d_minus};
        end
    end
    assign dp = dp_sync[1];
    assign dm = dm_sync[1];
`else
    assign dp = d_plus;
    assign dm = d_minus;
`endif

    state_t        state, state_n;
    logic [PW-1:0] phase, phase_n;
    logic [OW-1:0] ones_cnt, ones_n;
    logic          dp_q, prev_lvl, prev_lvl_n;
    logic          serial_q, serial_n;
    logic          shift_q, shift_n, eop_q, eop_n, serr_q, serr_n;

    // Combinational helpers
    logic          dp_edge, sample, se0, se1, lvl, bit_dec;
    logic [PW-1:0] phase_eff, phase_inc;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state    <= IDLE;
            phase    <= '0;
            ones_cnt <= '0;
            dp_q     <= 1'b1;
            prev_lvl <= 1'b1;
            serial_q <= 1'b1;
            shift_q  <= 1'b0;
            eop_q    <= 1'b0;
            serr_q   <= 1'b0;
        end else begin
            state    <= state_n;
            phase    <= phase_n;
            ones_cnt <= ones_n;
            dp_q     <= dp;
            prev_lvl <= prev_lvl_n;
            serial_q <= serial_n;
            shift_q  <= shift_n;
            eop_q    <= eop_n;
            serr_q   <= serr_n;
        end
    end

    always_comb begin
        state_n    = state;
        phase_n    = phase;
        ones_n     = ones_cnt;
        prev_lvl_n = prev_lvl;
        serial_n   = serial_q;
        shift_n    = 1'b0;
        eop_n      = 1'b0;
        serr_n     = 1'b0;

        // Any D+ transition resynchronises timing: the edge cycle is phase 0,
        // so an edge landing on the sample phase suppresses that sample.
        dp_edge   = dp ^ dp_q;
        phase_eff = dp_edge ? '0 : phase;
        phase_inc = (phase_eff == PW'(CLKS_PER_BIT - 1)) ? '0 : phase_eff + PW'(1);
        sample    = !dp_edge && (phase_eff == PW'(SAMPLE_OFFSET));
        se0       = !dp && !dm;
        se1       = dp && dm;
        lvl       = se1 ? prev_lvl : dp;     // SE1 repeats the previous level
        bit_dec   = (lvl == prev_lvl);       // NRZI: no change = 1

        case (state)
            IDLE: begin
                phase_n    = '0;
                ones_n     = '0;
                prev_lvl_n = 1'b1;           // first K then decodes as 0
                if (dp_q && !dp) begin
                    state_n = RUN;
                    phase_n = phase_inc;     // edge cycle was phase 0
                end
            end
            RUN: begin
                phase_n = phase_inc;
                if (sample) begin
                    if (se0) begin
                        // SE0 outranks stuff checking and produces no data bit
                        state_n = EOP_WAIT;
                        eop_n   = 1'b1;
                        ones_n  = '0;
                    end else begin
                        prev_lvl_n = lvl;
                        if (ones_cnt == OW'(STUFF_LIMIT)) begin
                            ones_n = '0;
                            if (bit_dec) begin
                                state_n = ERR_WAIT;
                                serr_n  = 1'b1;
                            end
                            // decoded 0 here is the stuffed bit: dropped
                        end else begin
                            shift_n  = 1'b1;
                            serial_n = bit_dec;
                            ones_n   = bit_dec ? ones_cnt + OW'(1) : '0;
                        end
                    end
                end
            end
            EOP_WAIT, ERR_WAIT: begin
                phase_n = phase_inc;
                if (sample && dp && !dm)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (!rx_enable) begin
            state_n    = IDLE;
            phase_n    = '0;
            ones_n     = '0;
            prev_lvl_n = 1'b1;
            serial_n   = serial_q;
            shift_n    = 1'b0;
            eop_n      = 1'b0;
            serr_n     = 1'b0;
        end
    end

    assign serial_out = serial_q;
    assign shift_en   = shift_q;
    assign eop        = eop_q;
    assign stuff_err  = serr_q;
    assign rcving     = (state == RUN);

endmodule
